// File: rtl/decode_n_seq_pkg.sv
// Shared definitions for the sequenced N-to-2^N decoder: request mode codes and FSM states.
package decode_n_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'd0,
    MODE_THERMO = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/decode_n_seq_if.sv
// Request/response handshake bundle of the sequenced decoder; slave is the decoder side.
interface decode_n_seq_if #(
  parameter int N = 3
);

  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       sel;
  logic               en;
  logic [1:0]         mode;
  logic [(2**N)-1:0]  y;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  modport master (
    output in_valid, sel, en, mode, out_ready,
    input  in_ready, y, out_valid, out_last
  );

  modport slave (
    input  in_valid, sel, en, mode, out_ready,
    output in_ready, y, out_valid, out_last
  );

endinterface

// File: rtl/decode_n_comb.sv
// Pure combinational N-to-2^N one-hot decoder with enable; all-zero when disabled.
module decode_n_comb #(
  parameter int N = 3
) (
  input  logic [N-1:0]      sel,
  input  logic              en,
  output logic [(2**N)-1:0] y
);

  localparam int OUT_W = 2**N;

  assign y = en ? (OUT_W'(1'b1) << sel) : {OUT_W{1'b0}};

endmodule

// File: rtl/decode_n_seq.sv
// Registered N-to-2^N decoder with ONEHOT/THERMO/SCAN modes and valid/ready on both sides.
module decode_n_seq #(
  parameter int N       = 3,
  parameter bit SCAN_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  decode_n_seq_if.slave bus
);

  import decode_n_seq_pkg::*;

  localparam int OUT_W = 2**N;

  state_e             state_r;
  logic [OUT_W-1:0]   y_r;
  logic               out_valid_r;
  logic               out_last_r;
  logic [N-1:0]       idx_r;
  logic [N-1:0]       scan_sel_r;

  mode_e              mode_s;
  logic               ready_s;
  logic               accept_s;
  logic               take_s;
  logic               is_scan_s;
  logic               is_thermo_s;
  logic               start_scan_s;
  logic               scan_done_s;
  logic [N-1:0]       idx_next_s;
  logic [OUT_W-1:0]   req_oh_s;
  logic [OUT_W-1:0]   thermo_s;
  logic [OUT_W-1:0]   step_oh_s;
  logic [OUT_W-1:0]   first_y_s;

  assign mode_s       = mode_e'(bus.mode);
  assign is_scan_s    = SCAN_EN && (mode_s == MODE_SCAN);
  assign is_thermo_s  = (mode_s == MODE_THERMO);

  // Ready never looks at in_valid, so upstream may wait on it without a loop.
  assign ready_s      = !rst && (state_r != ST_SCAN) && (!out_valid_r || bus.out_ready);
  assign accept_s     = bus.in_valid && ready_s;
  assign take_s       = out_valid_r && bus.out_ready;
  assign start_scan_s = accept_s && bus.en && is_scan_s && (bus.sel != {N{1'b0}});

  assign idx_next_s   = idx_r + N'(1'b1);
  assign scan_done_s  = (idx_next_s == scan_sel_r);

  decode_n_comb #(.N(N)) u_req_dec (
    .sel (bus.sel),
    .en  (bus.en),
    .y   (req_oh_s)
  );

  decode_n_comb #(.N(N)) u_step_dec (
    .sel (idx_next_s),
    .en  (1'b1),
    .y   (step_oh_s)
  );

  // Thermometer bit i is set when the one-hot bit sits at i or above.
  for (genvar i = 0; i < OUT_W; i++) begin : g_thermo
    assign thermo_s[i] = |req_oh_s[OUT_W-1:i];
  end

  // First beat loaded on accept; a scan always starts at bit 0.
  always_comb begin
    first_y_s = {OUT_W{1'b0}};
    if (!bus.en) begin
      first_y_s = {OUT_W{1'b0}};
    end else if (is_scan_s) begin
      first_y_s = OUT_W'(1'b1);
    end else if (is_thermo_s) begin
      first_y_s = thermo_s;
    end else begin
      first_y_s = req_oh_s;
    end
  end

  // Control FSM, scan index and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      y_r         <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      idx_r       <= {N{1'b0}};
      scan_sel_r  <= {N{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            y_r         <= first_y_s;
            out_valid_r <= 1'b1;
            out_last_r  <= !start_scan_s;
            if (start_scan_s) begin
              state_r    <= ST_SCAN;
              idx_r      <= {N{1'b0}};
              scan_sel_r <= bus.sel;
            end else begin
              state_r    <= ST_IDLE;
            end
          end else if (take_s) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        ST_SCAN: begin
          // The final beat is left in the register and drains under IDLE rules.
          if (take_s) begin
            y_r        <= step_oh_s;
            idx_r      <= idx_next_s;
            out_last_r <= scan_done_s;
            state_r    <= scan_done_s ? ST_IDLE : ST_SCAN;
          end else begin
            state_r    <= ST_SCAN;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.y         = y_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_decode_n_seq.sv
// Directed bench for decode_n_seq (N=3): single-request vector table plus scan, hold, reset and stream sequences.
module tb_decode_n_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  decode_n_seq_if #(.N(3)) bus ();

  decode_n_seq #(.N(3), .SCAN_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] sel;
    logic       en;
    logic [7:0] exp_y;
    logic       exp_last;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string name, input logic [7:0] ey, input logic el);
    chk({name, " y"}, {24'd0, bus.y}, {24'd0, ey});
    chk({name, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({name, " out_last"}, {31'd0, bus.out_last}, {31'd0, el});
  endtask

  task automatic req(input logic [1:0] m, input logic [2:0] s, input logic e);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.sel      = s;
    bus.en       = e;
  endtask

  logic [7:0] exp_q [$];
  int k;
  int got;
  int last_take;

  task automatic stream(input bit stall, input int exp_last_take);
    k = 0;
    got = 0;
    last_take = -1;
    exp_q.delete();
    for (int cyc = 0; cyc < 24 && got < 8; cyc++) begin
      bus.out_ready = !(stall && (cyc == 3 || cyc == 4));
      bus.in_valid  = (k < 8);
      bus.mode      = 2'd0;
      bus.en        = 1'b1;
      bus.sel       = 3'(k);
      #1;
      if (stall && !bus.out_ready && bus.out_valid)
        chk("stream stall in_ready", {31'd0, bus.in_ready}, 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream unexpected beat", {24'd0, bus.y}, 32'hFFFF_FFFF);
        end else begin
          chk("stream y", {24'd0, bus.y}, {24'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
        got++;
        last_take = cyc;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(8'd1 << k);
        k++;
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream beats", got, 32'd8);
    chk("stream accepted", k, 32'd8);
    chk("stream last take cycle", last_take, exp_last_take);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{2'd0, 3'd5, 1'b1, 8'h20, 1'b1};
    vecs[1]  = '{2'd0, 3'd5, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{2'd1, 3'd3, 1'b1, 8'h0F, 1'b1};
    vecs[3]  = '{2'd1, 3'd7, 1'b1, 8'hFF, 1'b1};
    vecs[4]  = '{2'd1, 3'd0, 1'b1, 8'h01, 1'b1};
    vecs[5]  = '{2'd1, 3'd6, 1'b0, 8'h00, 1'b1};
    vecs[6]  = '{2'd3, 3'd6, 1'b1, 8'h40, 1'b1};
    vecs[7]  = '{2'd2, 3'd0, 1'b1, 8'h01, 1'b1};
    vecs[8]  = '{2'd2, 3'd4, 1'b0, 8'h00, 1'b1};
    vecs[9]  = '{2'd0, 3'd0, 1'b1, 8'h01, 1'b1};
    vecs[10] = '{2'd0, 3'd7, 1'b1, 8'h80, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sel       = 3'd0;
    bus.en        = 1'b0;
    bus.mode      = 2'd0;
    bus.out_ready = 1'b1;

    // Reset
    step();
    step();
    chk("reset y", {24'd0, bus.y}, 32'd0);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single-request table, applied back to back
    for (int i = 0; i < 11; i++) begin
      req(vecs[i].mode, vecs[i].sel, vecs[i].en);
      #1;
      chk($sformatf("vec%0d in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      step();
      beat($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_last);
    end
    bus.in_valid = 1'b0;
    step();
    chk("drain out_valid", {31'd0, bus.out_valid}, 32'd0);

    // SCAN sel=3, a different request held pending during the scan
    req(2'd2, 3'd3, 1'b1);
    #1;
    chk("scan accept in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    beat("scan b0", 8'h01, 1'b0);
    req(2'd0, 3'd6, 1'b1);
    #1;
    chk("scan b0 in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    beat("scan b1", 8'h02, 1'b0);
    chk("scan b1 in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    beat("scan b2", 8'h04, 1'b0);
    chk("scan b2 in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    beat("scan b3", 8'h08, 1'b1);
    chk("scan last in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    beat("after scan", 8'h40, 1'b1);
    bus.in_valid = 1'b0;
    step();
    chk("after scan idle", {31'd0, bus.out_valid}, 32'd0);

    // SCAN sel=3 with backpressure on the second beat
    req(2'd2, 3'd3, 1'b1);
    step();
    bus.in_valid = 1'b0;
    beat("hold b0", 8'h01, 1'b0);
    step();
    beat("hold b1", 8'h02, 1'b0);
    bus.out_ready = 1'b0;
    #1;
    chk("hold in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    beat("hold b1 stall1", 8'h02, 1'b0);
    step();
    beat("hold b1 stall2", 8'h02, 1'b0);
    bus.out_ready = 1'b1;
    step();
    beat("hold b2", 8'h04, 1'b0);
    step();
    beat("hold b3", 8'h08, 1'b1);
    step();
    chk("hold idle", {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of a SCAN sel=7
    req(2'd2, 3'd7, 1'b1);
    step();
    bus.in_valid = 1'b0;
    beat("abort b0", 8'h01, 1'b0);
    step();
    beat("abort b1", 8'h02, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort in_ready during rst", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort y", {24'd0, bus.y}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    req(2'd0, 3'd1, 1'b1);
    step();
    bus.in_valid = 1'b0;
    beat("abort new", 8'h02, 1'b1);
    step();

    // Back-to-back ONEHOT streams, without and with a two-cycle stall
    stream(1'b0, 8);
    step();
    stream(1'b1, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
